text_scroller: RTL and testbench

//  Message buffer and scroll sequencer feeding the per-digit letter-to-7-seg decoders.

---
 rtl/text_scroller.sv | 139 +++++++++++++
 tb/tb_text_scroller.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/text_scroller.sv
// Message buffer and right-to-left scroll sequencer feeding per-digit letter decoders.
// Optional build macro SCROLL_LOOP_EN: repeat the pass until stop/reset instead of returning to IDLE.
module text_scroller #(
    parameter int N_DIGITS  = 4,
    parameter int MSG_DEPTH = 32,
    parameter int ADDR_W    = 5,
    parameter int TICK_DIV  = 25_000_000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [4:0]              wr_data,
    input  logic [ADDR_W:0]         msg_len,
    input  logic                    start,
    input  logic                    stop,
    output logic [5*N_DIGITS-1:0]   letras,
    output logic                    busy,
    output logic                    pass_done
);

    // state  | meaning
    // IDLE   | digits blank, waiting for start with a non-zero length
    // SCROLL | window position k advances once per TICK_DIV clocks

    localparam int K_W   = $clog2(MSG_DEPTH + N_DIGITS + 1);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] TICK_LOAD = CNT_W'(TICK_DIV - 1);
    localparam logic [ADDR_W:0]  LEN_MAX   = (ADDR_W+1)'(MSG_DEPTH);

    typedef enum logic {IDLE, SCROLL} state_t;

    state_t                  state_q, state_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_W:0]         len_q, len_d;
    logic [5*N_DIGITS-1:0]   letras_d;
    logic                    busy_d;
    logic                    pass_done_d;
    logic [5*N_DIGITS-1:0]   window;
    logic [K_W-1:0]          end_k;
    logic [4:0]              buffer [MSG_DEPTH];

    // Buffer is deliberately left out of reset so a message survives it.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            buffer[wr_addr] <= wr_data;
        end
    end

    // Digit j shows buffer[k-1-j] when that index falls inside the latched message.
    always_comb begin
        int idx;
        idx    = 0;
        window = '0;
        for (int j = 0; j < N_DIGITS; j++) begin
            idx = int'(k_q) - 1 - j;
            if (idx >= 0 && idx < int'(len_q)) begin
                window[5*j +: 5] = buffer[idx[ADDR_W-1:0]];
            end
        end
    end

    assign end_k = K_W'(len_q) + K_W'(N_DIGITS - 1);

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        letras_d    = '0;
        busy_d      = 1'b0;
        pass_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop && msg_len != '0) begin
                    state_d = SCROLL;
                    k_d     = K_W'(1);
                    cnt_d   = TICK_LOAD;
                    len_d   = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
                    busy_d  = 1'b1;
                end
            end
            SCROLL: begin
                busy_d   = 1'b1;
                letras_d = window;
                if (stop) begin
                    state_d  = IDLE;
                    k_d      = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b0;
                    letras_d = '0;
                end else if (cnt_q == '0) begin
                    cnt_d = TICK_LOAD;
                    if (k_q == end_k) begin
                        pass_done_d = 1'b1;
`ifdef SCROLL_LOOP_EN
                        k_d = K_W'(1);
`else
                        state_d  = IDLE;
                        k_d      = '0;
                        cnt_d    = '0;
                        busy_d   = 1'b0;
                        letras_d = '0;
`endif
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            letras    <= '0;
            busy      <= 1'b0;
            pass_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            letras    <= letras_d;
            busy      <= busy_d;
            pass_done <= pass_done_d;
        end
    end

endmodule

// File: tb/tb_text_scroller.sv
// Directed bench for text_scroller with TICK_DIV=4, N_DIGITS=4; follows SCROLL_LOOP_EN if defined.
module tb_text_scroller;
    localparam int N  = 4;
    localparam int DP = 32;
    localparam int AW = 5;
    localparam int TD = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [4:0]      wr_data;
    logic [AW:0]     msg_len;
    logic            start;
    logic            stop;
    logic [5*N-1:0]  letras;
    logic            busy;
    logic            pass_done;

    int total = 0;
    int bad   = 0;

`ifdef SCROLL_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    text_scroller #(.N_DIGITS(N), .MSG_DEPTH(DP), .ADDR_W(AW), .TICK_DIV(TD)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .msg_len(msg_len), .start(start), .stop(stop), .letras(letras), .busy(busy),
        .pass_done(pass_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [4:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step(1);
        wr_en   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        msg_len = '0; start = 1'b0; stop = 1'b0;

        // reset
        step(3);
        check("rst_letras", 32'(letras), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_pass_done", 32'(pass_done), 32'h0);
        reset = 1'b0;
        step(1);

        // basic pass with "ABC"
        write(5'd0, 5'd1);
        write(5'd1, 5'd2);
        write(5'd2, 5'd3);
        msg_len = 6'd3; start = 1'b1;
        step(1);
        start = 1'b0;
        check("start_busy", 32'(busy), 32'h1);
        for (int i = 1; i <= 24; i++) begin
            step(1);
            if (i == 1)  check("win_k1", 32'(letras), 32'h00001);
            if (i == 5)  check("win_k2", 32'(letras), 32'h00022);
            if (i == 9)  check("win_k3", 32'(letras), 32'h00443);
            if (i == 13) check("win_k4", 32'(letras), 32'h08860);
            if (i == 23) check("busy_before_end", 32'(busy), 32'h1);
            check("pass_done_t24", 32'(pass_done), (i == 24) ? 32'h1 : 32'h0);
        end
        check("busy_at_end", 32'(busy), LOOP ? 32'h1 : 32'h0);
        step(1);
        check("pass_done_falls", 32'(pass_done), 32'h0);
        check("letras_after_end", 32'(letras), LOOP ? 32'h00001 : 32'h0);
`ifdef SCROLL_LOOP_EN
        for (int i = 26; i <= 48; i++) begin
            step(1);
            check("pass_done_t48", 32'(pass_done), (i == 48) ? 32'h1 : 32'h0);
        end
        step(1);
        check("loop_letras_restart", 32'(letras), 32'h00001);
        check("loop_busy", 32'(busy), 32'h1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("loop_stop_busy", 32'(busy), 32'h0);
`endif

        // stop mid-pass together with start
        msg_len = 6'd3; start = 1'b1;
        step(1);
        start = 1'b0;
        step(7);
        check("mid_pass_window", 32'(letras), 32'h00022);
        stop = 1'b1; start = 1'b1;
        step(1);
        stop = 1'b0; start = 1'b0;
        check("stop_letras", 32'(letras), 32'h0);
        check("stop_busy", 32'(busy), 32'h0);
        check("stop_pass_done", 32'(pass_done), 32'h0);
        for (int i = 0; i < 30; i++) begin
            step(1);
            check("after_stop_quiet", 32'({busy, pass_done}), 32'h0);
        end
        stop = 1'b1; start = 1'b1;
        step(1);
        stop = 1'b0; start = 1'b0;
        check("idle_stop_start", 32'(busy), 32'h0);

        // zero length ignored
        msg_len = 6'd0; start = 1'b1;
        step(1);
        start = 1'b0;
        check("len0_busy", 32'(busy), 32'h0);
        step(5);
        check("len0_letras", 32'(letras), 32'h0);
        check("len0_quiet", 32'({busy, pass_done}), 32'h0);

        // clamped length; msg_len change and re-start ignored while scrolling
        msg_len = 6'd40; start = 1'b1;
        step(1);
        start = 1'b0; msg_len = 6'd3;
        cyc = 0;
        while (pass_done !== 1'b1 && cyc < 300) begin
            start = (cyc == 50);
            step(1);
            cyc++;
        end
        start = 1'b0;
        check("clamp_pass_len", 32'(cyc), 32'd140);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("clamp_end_busy", 32'(busy), 32'h0);

        // live write visible next cycle, then reset mid-pass
        msg_len = 6'd3; start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        check("live_before", 32'(letras), 32'h00001);
        write(5'd0, 5'h1a);
        check("live_latency", 32'(letras), 32'h00001);
        step(1);
        check("live_after", 32'(letras), 32'h0001a);
        reset = 1'b1;
        step(1);
        check("midrst_letras", 32'(letras), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_pass_done", 32'(pass_done), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            check("after_rst_quiet", 32'({busy, pass_done}), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
